mac_seq_unit: RTL and testbench

- Parametrised multi-cycle matrix MAC engine for the pipelined core's matrix extension.
- Executes the four matrix operations MADD, MSUB, MMUL and MLOAD on internal DIM x DIM operand banks A and B, writing results into bank C.
- The control path issues an operation with a start pulse. busy_o stalls the pipeline until done_o.
- C is read back one element per cycle for writeback.

---
 rtl/mac_seq_unit_pkg.sv | 14 +
 rtl/mac_dp.sv | 53 +++++
 rtl/mac_seq_unit.sv | 96 +++++++++
 tb/tb_mac_seq_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_unit_pkg.sv
// mac_seq_unit_pkg: shared types and defaults for the matrix MAC engine.
package mac_seq_unit_pkg;
  localparam int MAC_DIM_DEFAULT = 2;
  localparam int MAC_DATA_W_DEFAULT = 32;
  typedef logic [2:0] mac_control_t;
  typedef enum logic [1:0] {OP_MADD, OP_MSUB, OP_MMUL, OP_MLOAD} mac_op_t;
  typedef enum logic [2:0] {IDLE, LOAD, ADDSUB, MUL, DONE} mac_state_t;
  function automatic logic mac_legal(input mac_control_t c);
    return !c[2];
  endfunction
  function automatic mac_op_t mac_op(input mac_control_t c);
    return mac_op_t'(c[1:0]);
  endfunction
endpackage

// File: rtl/mac_dp.sv
// mac_dp: A/B/C bank storage, add/sub and multiply-accumulate datapath, C read port.
module mac_dp #(
  parameter int DATA_W = 32,
  parameter int DIM = 2,
  parameter int IDX_W = 2,
  parameter int CNT_W = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              as_we,
  input  logic              sub,
  input  logic              mul_en,
  input  logic [IDX_W-1:0]  e,
  input  logic [CNT_W-1:0]  i,
  input  logic [CNT_W-1:0]  j,
  input  logic [CNT_W-1:0]  k,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(DIM - 1);
  logic [DATA_W-1:0] a [DIM*DIM];
  logic [DATA_W-1:0] b [DIM*DIM];
  logic [DATA_W-1:0] c [DIM*DIM];
  logic [DATA_W-1:0] acc, prod, sum;
  logic [IDX_W-1:0] a_idx, b_idx, c_idx;
  always_comb begin
    a_idx = IDX_W'(i) * IDX_W'(DIM) + IDX_W'(k);
    b_idx = IDX_W'(k) * IDX_W'(DIM) + IDX_W'(j);
    c_idx = IDX_W'(i) * IDX_W'(DIM) + IDX_W'(j);
    prod = a[a_idx] * b[b_idx];
    sum = (k == '0 ? '0 : acc) + prod;
    rd_data = int'(rd_idx) < DIM * DIM ? c[rd_idx] : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      for (int n = 0; n < DIM * DIM; n++) begin
        a[n] <= '0;
        b[n] <= '0;
        c[n] <= '0;
      end
    end else begin
      if (ld_we && !ld_sel) a[e] <= ld_data;
      if (ld_we && ld_sel) b[e] <= ld_data;
      if (as_we) c[e] <= sub ? a[e] - b[e] : a[e] + b[e];
      if (mul_en) acc <= sum;
      if (mul_en && k == K_LAST) c[c_idx] <= sum;
    end
  end
endmodule

// File: rtl/mac_seq_unit.sv
// mac_seq_unit: multi-cycle DIMxDIM matrix MAC engine (MADD/MSUB/MMUL/MLOAD) with stall handshake.
module mac_seq_unit
  import mac_seq_unit_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W_DEFAULT,
  parameter int DIM = MAC_DIM_DEFAULT,
  parameter int IDX_W = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  mac_control_t      mac_control_i,
  input  logic              ld_sel_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] E_LAST = IDX_W'(DIM * DIM - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIM - 1);
  mac_state_t state, state_nx;
  mac_op_t op;
  logic sel, err, ld_we, e_last, i_last, j_last, k_last;
  logic [IDX_W-1:0] e;
  logic [CNT_W-1:0] i, j, k;
  always_comb begin
    ld_we = state == LOAD && ld_valid_i;
    e_last = e == E_LAST;
    i_last = i == C_LAST;
    j_last = j == C_LAST;
    k_last = k == C_LAST;
    busy_o = state == LOAD || state == ADDSUB || state == MUL;
    done_o = state == DONE;
    err_o = state == DONE && err;
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start_i ? IDLE :
                          !mac_legal(mac_control_i) ? DONE :
                          mac_op(mac_control_i) == OP_MLOAD ? LOAD :
                          mac_op(mac_control_i) == OP_MMUL ? MUL : ADDSUB;
      LOAD:    state_nx = ld_we && e_last ? DONE : LOAD;
      ADDSUB:  state_nx = e_last ? DONE : ADDSUB;
      MUL:     state_nx = i_last && j_last && k_last ? DONE : MUL;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op <= OP_MADD;
      sel <= 1'b0;
      err <= 1'b0;
      e <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_i) begin
        op <= mac_op(mac_control_i);
        sel <= ld_sel_i;
        err <= !mac_legal(mac_control_i);
        e <= '0;
        i <= '0;
        j <= '0;
        k <= '0;
      end
      if (ld_we || state == ADDSUB) e <= e + 1'b1;
      if (state == MUL) begin
        k <= k_last ? '0 : k + 1'b1;
        if (k_last) j <= j_last ? '0 : j + 1'b1;
        if (k_last && j_last) i <= i + 1'b1;
      end
    end
  end
  mac_dp #(.DATA_W(DATA_W), .DIM(DIM), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dp (
    .clk(clk),
    .reset_n(reset_n),
    .ld_we(ld_we),
    .ld_sel(sel),
    .ld_data(ld_data_i),
    .as_we(state == ADDSUB),
    .sub(op == OP_MSUB),
    .mul_en(state == MUL),
    .e(e),
    .i(i),
    .j(j),
    .k(k),
    .rd_idx(rd_idx_i),
    .rd_data(rd_data_o)
  );
endmodule

// File: tb/tb_mac_seq_unit.sv
// tb_mac_seq_unit: directed self-checking bench for mac_seq_unit (DIM=2, plus a DIM=3 instance for out-of-range reads).
module tb_mac_seq_unit;
  import mac_seq_unit_pkg::*;
  localparam mac_control_t C_MADD = 3'd0, C_MSUB = 3'd1, C_MMUL = 3'd2, C_MLOAD = 3'd3, C_BAD = 3'd5;
  logic clk = 0, reset_n = 0, start_i = 0, ld_sel_i = 0, ld_valid_i = 0;
  mac_control_t mac_control_i = '0;
  logic [31:0] ld_data_i = '0;
  logic [1:0] rd_idx_i = '0;
  logic [31:0] rd_data_o;
  logic busy_o, done_o, err_o;
  logic s3 = 0, v3 = 0, sel3 = 0;
  mac_control_t ctl3 = '0;
  logic [31:0] d3 = '0, rd3;
  logic [3:0] idx3 = '0;
  logic busy3, done3, err3;
  int total = 0, bad = 0;

  mac_seq_unit dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .mac_control_i(mac_control_i),
    .ld_sel_i(ld_sel_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
    .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  mac_seq_unit #(.DIM(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start_i(s3), .mac_control_i(ctl3),
    .ld_sel_i(sel3), .ld_valid_i(v3), .ld_data_i(d3),
    .rd_idx_i(idx3), .rd_data_o(rd3), .busy_o(busy3), .done_o(done3), .err_o(err3)
  );

  always #5 clk = ~clk;

  task automatic read_c(output logic [3:0][31:0] c);
    for (int n = 0; n < 4; n++) begin
      rd_idx_i = 2'(n);
      #1 c[n] = rd_data_o;
    end
  endtask

  task automatic run_op(input mac_control_t ctl, input logic hold, output int dcyc, output int bcnt,
                        output int dcnt, output int ecnt);
    dcyc = -1; bcnt = 0; dcnt = 0; ecnt = 0;
    mac_control_i = ctl;
    start_i = 1;
    @(posedge clk); #1 start_i = hold;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (busy_o) bcnt++;
      if (err_o) ecnt++;
      if (done_o) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
        start_i = 0;
      end
      @(posedge clk); #1;
    end
    start_i = 0;
  endtask

  task automatic load(input logic sel, input logic [3:0][31:0] w, input logic [3:0] gap,
                      output logic busy_mid, output logic done_mid, output logic done_after);
    mac_control_i = C_MLOAD;
    ld_sel_i = sel;
    start_i = 1;
    @(posedge clk); #1 start_i = 0;
    for (int n = 0; n < 4; n++) begin
      if (gap[n]) begin @(posedge clk); #1; end
      ld_valid_i = 1;
      ld_data_i = w[n];
      @(posedge clk); #1 ld_valid_i = 0;
      if (n == 2) begin busy_mid = busy_o; done_mid = done_o; end
    end
    done_after = done_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [3:0][31:0] c;
    #1;
    total += 3;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    read_c(c);
    total++;
    if (c !== '0) begin bad++; $display("FAIL reset_c got=%h exp=0", c); end
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic load_checked(input string nm, input logic sel, input logic [3:0][31:0] w,
                              input logic [3:0] gap);
    logic bm, dm, da;
    load(sel, w, gap, bm, dm, da);
    total += 3;
    if (bm !== 1'b1) begin bad++; $display("FAIL %s_busy_mid got=%b exp=1", nm, bm); end
    if (dm !== 1'b0) begin bad++; $display("FAIL %s_done_early got=%b exp=0", nm, dm); end
    if (da !== 1'b1) begin bad++; $display("FAIL %s_done got=%b exp=1", nm, da); end
  endtask

  task automatic test_load;
    logic [3:0][31:0] c;
    load_checked("load_a", 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1010);
    load_checked("load_b", 1'b1, {32'd8, 32'd7, 32'd6, 32'd5}, 4'b0000);
    read_c(c);
    total++;
    if (c !== '0) begin bad++; $display("FAIL load_c_untouched got=%h exp=0", c); end
  endtask

  task automatic test_arith(input string nm, input mac_control_t ctl, input logic hold, input int exp_cyc,
                            input int exp_busy, input int exp_err, input logic [3:0][31:0] exp_c);
    int dcyc, bcnt, dcnt, ecnt;
    logic [3:0][31:0] c;
    run_op(ctl, hold, dcyc, bcnt, dcnt, ecnt);
    total += 4;
    if (dcyc !== exp_cyc) begin bad++; $display("FAIL %s_done_cycle got=%0d exp=%0d", nm, dcyc, exp_cyc); end
    if (bcnt !== exp_busy) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, bcnt, exp_busy); end
    if (dcnt !== 1) begin bad++; $display("FAIL %s_done_count got=%0d exp=1", nm, dcnt); end
    if (ecnt !== exp_err) begin bad++; $display("FAIL %s_err got=%0d exp=%0d", nm, ecnt, exp_err); end
    read_c(c);
    for (int n = 0; n < 4; n++) begin
      total++;
      if (c[n] !== exp_c[n]) begin bad++; $display("FAIL %s_c%0d got=%h exp=%h", nm, n, c[n], exp_c[n]); end
    end
  endtask

  task automatic test_overflow;
    load_checked("ovf_a", 1'b0, {4{32'hFFFF_FFFF}}, 4'b0000);
    load_checked("ovf_b", 1'b1, {4{32'd2}}, 4'b0100);
    test_arith("ovf_mmul", C_MMUL, 1'b0, 9, 8, 0, {4{32'hFFFF_FFFC}});
  endtask

  task automatic test_reset_mid;
    logic [3:0][31:0] c;
    mac_control_i = C_MMUL;
    start_i = 1;
    @(posedge clk); #1 start_i = 0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 0;
    #1;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    read_c(c);
    total++;
    if (c !== '0) begin bad++; $display("FAIL midrst_c got=%h exp=0", c); end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (done_o !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done_o); end
    end
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;
    test_arith("post_rst_madd", C_MADD, 1'b0, 5, 4, 0, '0);
  endtask

  task automatic test_out_of_range;
    logic [3:0] idx [4] = '{4'd4, 4'd8, 4'd9, 4'd15};
    logic [31:0] exp [4] = '{32'd5, 32'd9, 32'd0, 32'd0};
    ctl3 = C_MLOAD;
    s3 = 1;
    @(posedge clk); #1 s3 = 0;
    for (int n = 0; n < 9; n++) begin
      v3 = 1;
      d3 = 32'(n + 1);
      @(posedge clk); #1 v3 = 0;
    end
    @(posedge clk); #1 ctl3 = C_MADD;
    s3 = 1;
    @(posedge clk); #1 s3 = 0;
    repeat (11) begin @(posedge clk); #1; end
    for (int n = 0; n < 4; n++) begin
      idx3 = idx[n];
      #1;
      total++;
      if (rd3 !== exp[n]) begin bad++; $display("FAIL oor_rd%0d got=%h exp=%h", idx[n], rd3, exp[n]); end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_arith("madd", C_MADD, 1'b0, 5, 4, 0, {32'd12, 32'd10, 32'd8, 32'd6});
    test_arith("msub", C_MSUB, 1'b0, 5, 4, 0, {4{32'hFFFF_FFFC}});
    test_arith("mmul", C_MMUL, 1'b0, 9, 8, 0, {32'd50, 32'd43, 32'd22, 32'd19});
    test_arith("illegal", C_BAD, 1'b0, 1, 0, 1, {32'd50, 32'd43, 32'd22, 32'd19});
    test_arith("madd_after_bad", C_MADD, 1'b0, 5, 4, 0, {32'd12, 32'd10, 32'd8, 32'd6});
    test_arith("mmul_hold", C_MMUL, 1'b1, 9, 8, 0, {32'd50, 32'd43, 32'd22, 32'd19});
    test_overflow;
    test_out_of_range;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
